// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take WIDTH+1 cycles; MTHI/MTLO write in a single cycle.
//
// state | meaning
// IDLE  | waiting for a request; MTHI/MTLO handled here
// CALC  | one shift-add or restoring-divide iteration per edge
// FIX   | sign correction, HI/LO write, done pulse on the next cycle
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [5:0]       funct_i6,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc, acc_step, prod;
  logic [WIDTH-1:0]     opb, op_a, mag_a, mag_b;
  logic [WIDTH-1:0]     res_hi, res_lo, hi_q, lo_q;
  logic [WIDTH:0]       msum, rtop, rdiff;
  logic                 is_div, neg_q, neg_r, div_zero, done_q;
  logic                 idle_req, req_muldiv, req_signed, accept, last_iter;

  assign idle_req   = (state == IDLE) && start_i && !abort_i;
  assign req_muldiv = (funct_i6 == F_MULT) || (funct_i6 == F_MULTU) ||
                      (funct_i6 == F_DIV)  || (funct_i6 == F_DIVU);
  assign accept     = idle_req && req_muldiv;
  // Even funct codes in the MULT/DIV group are the signed variants.
  assign req_signed = ~funct_i6[0];
  assign mag_a      = (req_signed && a_i[WIDTH-1]) ? -a_i : a_i;
  assign mag_b      = (req_signed && b_i[WIDTH-1]) ? -b_i : b_i;
  assign last_iter  = (cnt == CNT_W'(WIDTH - 1));

  assign busy_o = (state != IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: begin
        if (abort_i)        state_nxt = IDLE;
        else if (last_iter) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // acc holds {partial product | remainder, multiplier | dividend/quotient}.
  always_comb begin
    msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} +
               (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    rtop     = acc[2*WIDTH-1:WIDTH-1];
    rdiff    = rtop - {1'b0, opb};
    acc_step = acc;
    if (is_div)
      acc_step = {(rdiff[WIDTH] ? rtop[WIDTH-1:0] : rdiff[WIDTH-1:0]),
                  acc[WIDTH-2:0], ~rdiff[WIDTH]};
    else
      acc_step = {msum, acc[WIDTH-1:1]};
  end

  always_comb begin
    prod   = neg_q ? -acc : acc;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        res_hi = op_a;
        res_lo = '1;
      end else begin
        res_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        res_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      op_a     <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (idle_req && funct_i6 == F_MTHI) hi_q <= a_i;
      if (idle_req && funct_i6 == F_MTLO) lo_q <= a_i;
      if (accept) begin
        cnt      <= '0;
        acc      <= {{WIDTH{1'b0}}, mag_a};
        opb      <= mag_b;
        op_a     <= a_i;
        is_div   <= funct_i6[1];
        neg_q    <= req_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        neg_r    <= req_signed && a_i[WIDTH-1];
        div_zero <= (b_i == '0);
      end
      if (state == CALC && !abort_i) begin
        acc <= acc_step;
        cnt <= cnt + CNT_W'(1);
      end
      if (state == FIX && !abort_i) begin
        hi_q   <= res_hi;
        lo_q   <= res_lo;
        done_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter at WIDTH=32 and WIDTH=8: directed cases, abort/reset
// behaviour and random MULT/DIV traffic checked against an arithmetic model.
module tb_mdu_iter;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, sel8 = 1'b0;
  logic [5:0]  funct = 6'h0;
  logic [31:0] a_d = '0, b_d = '0;

  logic        busy32, done32, busy8, done8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;
  logic        busy_s, done_s;
  logic [31:0] hi_s, lo_s;

  int ncmp = 0;
  int nerr = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .start_i(start & ~sel8), .funct_i6(funct),
    .a_i(a_d), .b_i(b_d), .abort_i(abort & ~sel8),
    .busy_o(busy32), .done_o(done32), .hi_o(hi32), .lo_o(lo32));

  mdu_iter #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start & sel8), .funct_i6(funct),
    .a_i(a_d[7:0]), .b_i(b_d[7:0]), .abort_i(abort & sel8),
    .busy_o(busy8), .done_o(done8), .hi_o(hi8), .lo_o(lo8));

  assign busy_s = sel8 ? busy8 : busy32;
  assign done_s = sel8 ? done8 : done32;
  assign hi_s   = sel8 ? {24'h0, hi8} : hi32;
  assign lo_s   = sel8 ? {24'h0, lo8} : lo32;

  // Reference: plain integer arithmetic at width w, returns {hi, lo}.
  function automatic logic [63:0] ref_mdu(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
    logic [63:0] mask, ua, ub, p, hi, lo;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'h0, a} & mask;
    ub = {32'h0, b} & mask;
    sa = $signed(ua << (64 - w)) >>> (64 - w);
    sb = $signed(ub << (64 - w)) >>> (64 - w);
    hi = '0;
    lo = '0;
    case (f)
      F_MULT:  begin p = sa * sb; hi = (p >> w) & mask; lo = p & mask; end
      F_MULTU: begin p = ua * ub; hi = (p >> w) & mask; lo = p & mask; end
      F_DIV, F_DIVU: begin
        if (ub == 0) begin
          hi = ua;
          lo = mask;
        end else if (f == F_DIV) begin
          q = sa / sb; r = sa % sb;
          lo = q & mask; hi = r & mask;
        end else begin
          lo = (ua / ub) & mask; hi = (ua % ub) & mask;
        end
      end
      default: ;
    endcase
    return {hi[31:0], lo[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic ab);
    @(negedge clk);
    start = 1'b1; funct = f; a_d = a; b_d = b; abort = ab;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [63:0] exp;
    int w, nbusy, ndone;
    w = sel8 ? 8 : 32;
    exp = ref_mdu(f, a, b, w);
    issue(f, a, b, 1'b0);
    nbusy = 0;
    ndone = 0;
    while (busy_s && nbusy < 200) begin
      nbusy++;
      if (done_s) ndone++;
      @(posedge clk);
      #1;
    end
    check({tag, " busy"}, 64'(nbusy), 64'(w + 1));
    check({tag, " hi"}, {32'h0, hi_s}, {32'h0, exp[63:32]});
    check({tag, " lo"}, {32'h0, lo_s}, {32'h0, exp[31:0]});
    if (done_s) ndone++;
    @(posedge clk);
    #1;
    if (done_s) ndone++;
    check({tag, " done"}, 64'(ndone), 64'd1);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  task automatic run_random(input int n);
    logic [5:0]  f;
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      f = F_MULT + 6'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = sel8 ? 32'h80 : 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(f, a, b, "rand");
    end
  endtask

  initial begin
    int ndone, nbusy;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {63'h0, busy32}, 64'd0);
    check("reset done", {63'h0, done32}, 64'd0);
    check("reset hi", {32'h0, hi32}, 64'd0);
    check("reset lo", {32'h0, lo32}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(F_MTHI, 32'h1234, 32'h0, 1'b0);
    check("mthi hi", {32'h0, hi_s}, 64'h1234);
    check("mthi busy", {63'h0, busy_s}, 64'd0);
    check("mthi done", {63'h0, done_s}, 64'd0);
    issue(F_MTLO, 32'hABCD, 32'h0, 1'b0);
    check("mtlo lo", {32'h0, lo_s}, 64'hABCD);
    check("mtlo hi kept", {32'h0, hi_s}, 64'h1234);
    check("mtlo busy", {63'h0, busy_s}, 64'd0);
    m_hi = 32'h1234;
    m_lo = 32'hABCD;

    issue(6'h20, 32'h5555, 32'h3, 1'b0);
    check("bad funct busy", {63'h0, busy_s}, 64'd0);
    check("bad funct hi", {32'h0, hi_s}, {32'h0, m_hi});
    issue(F_MULT, 32'd5, 32'd5, 1'b1);
    check("abort+start idle busy", {63'h0, busy_s}, 64'd0);
    issue(F_MTHI, 32'h77, 32'h0, 1'b1);
    check("abort+mthi hi", {32'h0, hi_s}, {32'h0, m_hi});

    run_op(F_MULT, 32'hFFFF_FFFD, 32'd7, "mult32");
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu32");
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, "div32");
    run_op(F_DIVU, 32'd100, 32'd0, "divu0_32");
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "divovf32");

    issue(F_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; funct = F_MULT; a_d = 32'd3; b_d = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort pre busy", {63'h0, busy_s}, 64'd1);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort busy", {63'h0, busy_s}, 64'd0);
    check("abort hi", {32'h0, hi_s}, {32'h0, m_hi});
    check("abort lo", {32'h0, lo_s}, {32'h0, m_lo});
    ndone = 0;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_s) ndone++;
      if (busy_s) nbusy++;
      @(posedge clk);
      #1;
    end
    check("abort done", 64'(ndone), 64'd0);
    check("abort no requeue", 64'(nbusy), 64'd0);

    run_random(25);

    issue(F_MULT, 32'd1234, 32'd5678, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    check("rst pre busy", {63'h0, busy_s}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst busy", {63'h0, busy_s}, 64'd0);
    check("rst hi", {32'h0, hi_s}, 64'd0);
    check("rst lo", {32'h0, lo_s}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;

    sel8 = 1'b1;
    run_op(F_MULT, 32'hFFFF_FFFD, 32'd7, "mult8");
    run_op(F_MULTU, 32'hFF, 32'hFF, "multu8");
    run_op(F_DIV, 32'hF9, 32'd2, "div8");
    run_op(F_DIVU, 32'd100, 32'd0, "divu0_8");
    run_op(F_DIV, 32'h80, 32'hFF, "divovf8");
    run_random(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the MIPS pipeline. Owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU over multiple cycles, and MTHI/MTLO in one cycle. HI/LO are always readable for MFHI/MFLO.
- Sits in EX beside the combinational ALU. The hazard unit stalls on busy_o. Generalised in WIDTH, with signed/unsigned modes, abort and a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand and HI/LO width. Must be even and >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width. Derived; do not override.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  request; sampled only while idle.
- funct_i6  in  6  MIPS funct code of the request.
- a_i  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- b_i  in  WIDTH  rt operand: multiplier or divisor.
- abort_i  in  1  pipeline flush; cancels an in-flight operation.
- busy_o  out  1  high while an operation is in flight.
- done_o  out  1  one-cycle pulse when HI/LO take a MULT/DIV result.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.

Behaviour:
- Funct codes:
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU.
  - 0x11 MTHI, 0x13 MTLO.
  - Any other funct with start_i is ignored: no state change.
- Reset (async, any state): state=IDLE, counter=0, hi_o=0, lo_o=0, busy_o=0, done_o=0.
- States: IDLE, CALC, FIX. busy_o = (state != IDLE), decoded combinationally from registered state.
- IDLE:
  - start_i with MTHI/MTLO: the next edge writes a_i to HI or LO. Stay IDLE, no busy, no done.
  - start_i with MULT/MULTU/DIV/DIVU: latch operands and op type, take magnitudes if signed, counter=0, go to CALC.
- CALC, one iteration per edge:
  - Multiply: radix-2 shift-add on a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per edge.
  - After WIDTH edges (counter == WIDTH-1 at the edge) go to FIX.
- FIX:
  - Apply sign correction. Signed product is negated if the operand signs differ. Quotient is negated if signs differ. Remainder takes the sign of the dividend.
  - Write HI/LO, set done_o=1 for exactly the following cycle, return to IDLE.
- Latency: start sampled at edge 0; HI/LO updated at edge WIDTH+1; done_o high during the cycle after that edge. busy_o is high for WIDTH+1 cycles.
- Result mapping:
  - Multiply: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2*WIDTH product.
  - Divide: LO = quotient, HI = remainder.
- Divide by zero: defined result, HI = a_i (dividend), LO = all ones. Still takes the full latency.
- Signed overflow (most-negative / -1): LO = most-negative (wraps), HI = 0.
- start_i while busy: ignored. Does not queue, does not disturb the operation.
- abort_i while busy: the next edge returns to IDLE. HI/LO unchanged, no done pulse.
- abort_i while IDLE: no effect.
- abort_i together with a new start in IDLE: abort wins, nothing is started.
- Reset mid-operation: immediate IDLE, HI/LO cleared.
- hi_o/lo_o are direct register outputs. During CALC they hold their previous values; the pipeline must stall MFHI/MFLO while busy_o.

Test Plan:
- Reset, then MTHI a=0x1234 and MTLO a=0xABCD (WIDTH=32) -> hi_o=0x00001234, lo_o=0x0000ABCD one edge later; busy_o stays 0, done_o stays 0.
- MULT a=-3 (0xFFFFFFFD), b=7 -> after 33 edges hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB; done_o pulses once; busy_o high exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001.
- DIV a=-7, b=2 -> lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1).
- DIVU a=100, b=0 -> hi_o=100, lo_o=0xFFFFFFFF.
- DIV a=0x80000000, b=-1 -> lo_o=0x80000000, hi_o=0.
- Start DIVU 100/7, then pulse start_i (MULT) at cycle 5 and abort_i at cycle 10 -> second start ignored; IDLE after abort; HI/LO keep prior values; no done_o.
- Assert rst_i at cycle 12 of a MULT -> busy_o=0, hi_o=lo_o=0 immediately (asynchronous).
- Rerun the MULT/DIV cases with WIDTH=8 -> correct results, latency 9 edges.
